// File: rtl/bip_boot_pkg.sv
// Shared state encoding, protocol byte values and a width helper for the boot sequencer.
package bip_boot_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DAT_HI,
        ST_DAT_LO,
        ST_WRITE,
        ST_ACK,
        ST_NAK,
        ST_RUN
    } boot_state_e;

    localparam logic [7:0] CMD_LOAD    = 8'hA5;
    localparam logic [7:0] CMD_RUN     = 8'hC3;
    localparam logic [7:0] CMD_STOP    = 8'h3C;
    localparam logic [7:0] RSP_ACK     = 8'h5A;
    localparam logic [7:0] RSP_ERR_LEN = 8'hFF;
    localparam logic [7:0] RSP_ERR_TMO = 8'hFE;

    // Number of bits needed to represent value (clogb2(2047) = 11).
    function automatic int clogb2(input int value);
        int v;
        int bits;
        v    = value;
        bits = 0;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/bip_boot_tx_hold.sv
// One-entry response register: holds a byte for the UART transmitter until accepted.
module bip_boot_tx_hold #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (i_load) begin
            valid_q <= 1'b1;
            data_q  <= i_data;
        end else if (valid_q && i_ready) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: rtl/bip_boot_ctrl.sv
// Boot/run sequencer: parses LOAD/RUN/STOP bytes, writes instruction memory, gates the CPU.
// Define BIP_BOOT_TIMEOUT_EN to NAK (0xFE) a frame that stalls for TIMEOUT_CYCLES.
module bip_boot_ctrl
    import bip_boot_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int UART_DATA_SIZE = 8,
    parameter int INS_MEM_DEPTH  = 2048,
    parameter int ADDR_WIDTH     = clogb2(INS_MEM_DEPTH - 1),
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_rx_valid,
    input  logic [UART_DATA_SIZE-1:0] i_rx_data,
    output logic                      o_tx_valid,
    output logic [UART_DATA_SIZE-1:0] o_tx_data,
    input  logic                      i_tx_ready,
    output logic                      o_imem_we,
    output logic [ADDR_WIDTH-1:0]     o_imem_addr,
    output logic [DATA_WIDTH-1:0]     o_imem_data,
    output logic                      o_cpu_enable,
    input  logic                      i_cpu_halt,
    output logic                      o_busy
);

    localparam int CW = ADDR_WIDTH + 1;

    localparam logic [UART_DATA_SIZE-1:0] B_LOAD    = UART_DATA_SIZE'(CMD_LOAD);
    localparam logic [UART_DATA_SIZE-1:0] B_RUN     = UART_DATA_SIZE'(CMD_RUN);
    localparam logic [UART_DATA_SIZE-1:0] B_STOP    = UART_DATA_SIZE'(CMD_STOP);
    localparam logic [UART_DATA_SIZE-1:0] B_ACK     = UART_DATA_SIZE'(RSP_ACK);
    localparam logic [UART_DATA_SIZE-1:0] B_ERR_LEN = UART_DATA_SIZE'(RSP_ERR_LEN);
    localparam logic [DATA_WIDTH-1:0]     DEPTH_L   = DATA_WIDTH'(INS_MEM_DEPTH);
    localparam logic [CW-1:0]             CNT_ONE   = CW'(1);
    localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE  = ADDR_WIDTH'(1);

    if (DATA_WIDTH != 2 * UART_DATA_SIZE || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("bip_boot_ctrl: DATA_WIDTH must be 2*UART_DATA_SIZE and TIMEOUT_CYCLES >= 1");
    end

    boot_state_e               state_q;
    logic [UART_DATA_SIZE-1:0] len_hi_q;
    logic [CW-1:0]             len_q;
    logic [CW-1:0]             word_cnt_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [UART_DATA_SIZE-1:0] hi_byte_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic                      we_q;
    logic                      cpu_en_q;
    logic                      busy_q;

    logic [DATA_WIDTH-1:0]     len_full;
    logic                      last_word;
    logic                      tx_load;
    logic [UART_DATA_SIZE-1:0] tx_code;
    logic                      tx_valid;
    logic                      tx_hs;
    logic                      stop_cmd;

    assign len_full  = {len_hi_q, i_rx_data};
    assign last_word = (word_cnt_q == len_q - CNT_ONE);
    assign tx_hs     = tx_valid && i_tx_ready;
    assign stop_cmd  = i_rx_valid && (i_rx_data == B_STOP);

`ifdef BIP_BOOT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [UART_DATA_SIZE-1:0] B_ERR_TMO = UART_DATA_SIZE'(RSP_ERR_TMO);

    logic [TW-1:0] tmo_q;
    logic          waiting;
    logic          tmo_hit;

    assign waiting = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                     (state_q == ST_DAT_HI) || (state_q == ST_DAT_LO);
    assign tmo_hit = waiting && !i_rx_valid && (tmo_q == TMO_LAST);

    // Reloads on every accepted byte so the limit is an inter-byte gap, not a frame length.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_q <= '0;
        end else if (!waiting || i_rx_valid) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end
`endif

    always_comb begin
        tx_load = 1'b0;
        tx_code = B_ACK;
        if (state_q == ST_LEN_LO && i_rx_valid) begin
            if (len_full > DEPTH_L) begin
                tx_load = 1'b1;
                tx_code = B_ERR_LEN;
            end else if (len_full == '0) begin
                tx_load = 1'b1;
            end
        end
        if (state_q == ST_WRITE && last_word) begin
            tx_load = 1'b1;
        end
`ifdef BIP_BOOT_TIMEOUT_EN
        if (tmo_hit) begin
            tx_load = 1'b1;
            tx_code = B_ERR_TMO;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            len_hi_q   <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            hi_byte_q  <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            cpu_en_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_rx_valid && i_rx_data == B_LOAD) begin
                        state_q <= ST_LEN_HI;
                        busy_q  <= 1'b1;
                    end else if (i_rx_valid && i_rx_data == B_RUN) begin
                        state_q  <= ST_RUN;
                        cpu_en_q <= 1'b1;
                    end
                end
                ST_LEN_HI: begin
                    if (i_rx_valid) begin
                        len_hi_q <= i_rx_data;
                        state_q  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (i_rx_valid) begin
                        if (len_full > DEPTH_L) begin
                            state_q <= ST_NAK;
                        end else if (len_full == '0) begin
                            state_q <= ST_ACK;
                        end else begin
                            len_q      <= len_full[CW-1:0];
                            word_cnt_q <= '0;
                            addr_q     <= '0;
                            state_q    <= ST_DAT_HI;
                        end
                    end
                end
                ST_DAT_HI: begin
                    if (i_rx_valid) begin
                        hi_byte_q <= i_rx_data;
                        state_q   <= ST_DAT_LO;
                    end
                end
                ST_DAT_LO: begin
                    if (i_rx_valid) begin
                        wdata_q <= {hi_byte_q, i_rx_data};
                        we_q    <= 1'b1;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Address stays on the last word so a full-depth load never wraps to 0.
                    we_q       <= 1'b0;
                    word_cnt_q <= word_cnt_q + CNT_ONE;
                    if (last_word) begin
                        state_q <= ST_ACK;
                    end else begin
                        addr_q  <= addr_q + ADDR_ONE;
                        state_q <= ST_DAT_HI;
                    end
                end
                ST_ACK: begin
                    if (tx_hs) begin
                        state_q  <= ST_RUN;
                        cpu_en_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                ST_NAK: begin
                    if (tx_hs) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (i_cpu_halt || stop_cmd) begin
                        state_q  <= ST_IDLE;
                        cpu_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    we_q     <= 1'b0;
                    cpu_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
`ifdef BIP_BOOT_TIMEOUT_EN
            if (tmo_hit) begin
                state_q <= ST_NAK;
            end
`endif
        end
    end

    bip_boot_tx_hold #(
        .WIDTH (UART_DATA_SIZE)
    ) u_tx_hold (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (tx_load),
        .i_data  (tx_code),
        .i_ready (i_tx_ready),
        .o_valid (tx_valid),
        .o_data  (o_tx_data)
    );

    assign o_tx_valid   = tx_valid;
    assign o_imem_we    = we_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_data  = wdata_q;
    assign o_cpu_enable = cpu_en_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_bip_boot_ctrl.sv
// Directed bench for bip_boot_ctrl: load, NAK, run/halt/stop, ACK back-pressure, reset, full depth.
module tb_bip_boot_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        imem_we;
    logic [10:0] imem_addr;
    logic [15:0] imem_data;
    logic        cpu_enable;
    logic        cpu_halt;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    int we_double = 0;
    logic we_prev = 1'b0;
    logic [15:0] mem_seen [0:2047];

    bip_boot_ctrl #(
        .DATA_WIDTH     (16),
        .UART_DATA_SIZE (8),
        .INS_MEM_DEPTH  (2048),
        .ADDR_WIDTH     (11),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data),
        .o_tx_valid   (tx_valid),
        .o_tx_data    (tx_data),
        .i_tx_ready   (tx_ready),
        .o_imem_we    (imem_we),
        .o_imem_addr  (imem_addr),
        .o_imem_data  (imem_data),
        .o_cpu_enable (cpu_enable),
        .i_cpu_halt   (cpu_halt),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            if (we_prev) we_double++;
            we_cnt++;
            mem_seen[imem_addr] = imem_data;
        end
        we_prev = imem_we;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int limit, output int cyc);
        cyc = 0;
        while (!tx_valid && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int bad;
        int we_base;
        logic [15:0] w;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        cpu_halt = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_we", imem_we, 0);
        check_eq("rst_addr", imem_addr, 0);
        check_eq("rst_data", imem_data, 0);
        check_eq("rst_cpu_en", cpu_enable, 0);
        check_eq("rst_busy", busy, 0);
        $display("txn reset: outputs checked");

        // Two-word load with ACK back-pressure for 20 cycles.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        check_eq("load_busy", busy, 1);
        send_byte(8'h12); send_byte(8'h34);
        check_eq("w0_we", imem_we, 1);
        check_eq("w0_addr", imem_addr, 0);
        check_eq("w0_data", imem_data, 16'h1234);
        send_byte(8'hAB); send_byte(8'hCD);
        check_eq("w1_we", imem_we, 1);
        check_eq("w1_addr", imem_addr, 1);
        check_eq("w1_data", imem_data, 16'hABCD);
        @(posedge clk); #1;
        check_eq("ack_we_low", imem_we, 0);
        check_eq("ack_valid", tx_valid, 1);
        check_eq("ack_data", tx_data, 8'h5A);
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (tx_valid !== 1'b1 || tx_data !== 8'h5A || cpu_enable !== 1'b0 || busy !== 1'b1) bad++;
        end
        check_eq("ack_hold_bad_cycles", bad, 0);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("ack_hs_cpu_en", cpu_enable, 1);
        check_eq("ack_hs_tx_valid", tx_valid, 0);
        check_eq("ack_hs_busy", busy, 0);
        check_eq("load2_we_cnt", we_cnt, 2);
        check_eq("load2_we_double", we_double, 0);
        check_eq("load2_mem0", mem_seen[0], 16'h1234);
        check_eq("load2_mem1", mem_seen[1], 16'hABCD);
        $display("txn load2: 0x1234@0 0xABCD@1 ack");

        send_byte(8'h00);
        check_eq("run_ignore_byte", cpu_enable, 1);
        send_byte(8'h3C);
        check_eq("stop_cpu_en", cpu_enable, 0);
        check_eq("stop_busy", busy, 0);
        $display("txn stop: cpu disabled");

        // Oversized length is rejected.
        send_byte(8'hA5); send_byte(8'h08); send_byte(8'h01);
        check_eq("nak_valid", tx_valid, 1);
        check_eq("nak_data", tx_data, 8'hFF);
        check_eq("nak_busy", busy, 1);
        @(posedge clk); #1;
        check_eq("nak_hs_valid", tx_valid, 0);
        check_eq("nak_hs_busy", busy, 0);
        check_eq("nak_cpu_en", cpu_enable, 0);
        check_eq("nak_we_cnt", we_cnt, 2);
        $display("txn nak: len 0x0801 rejected");

        send_byte(8'h3C); send_byte(8'h55);
        check_eq("idle_junk_busy", busy, 0);
        check_eq("idle_junk_cpu", cpu_enable, 0);

        // RUN, halt pulse, then halt and STOP together.
        send_byte(8'hC3);
        check_eq("run_cpu_en", cpu_enable, 1);
        check_eq("run_busy", busy, 0);
        @(posedge clk); #1 cpu_halt = 1'b1;
        @(posedge clk); #1 cpu_halt = 1'b0;
        check_eq("halt_cpu_en", cpu_enable, 0);
        send_byte(8'hC3);
        check_eq("run2_cpu_en", cpu_enable, 1);
        @(posedge clk); #1;
        cpu_halt = 1'b1; rx_valid = 1'b1; rx_data = 8'h3C;
        @(posedge clk); #1;
        cpu_halt = 1'b0; rx_valid = 1'b0;
        check_eq("halt_stop_cpu_en", cpu_enable, 0);
        send_byte(8'hC3);
        check_eq("run3_cpu_en", cpu_enable, 1);
        send_byte(8'h3C);
        check_eq("run3_stop", cpu_enable, 0);
        $display("txn run: halt, halt+stop, rerun");

        // Zero-length load acknowledges straight away.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        check_eq("len0_valid", tx_valid, 1);
        check_eq("len0_data", tx_data, 8'h5A);
        @(posedge clk); #1;
        check_eq("len0_cpu_en", cpu_enable, 1);
        check_eq("len0_we_cnt", we_cnt, 2);
        send_byte(8'h3C);
        $display("txn len0: ack");

        // Second load restarts at address 0.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hBE); send_byte(8'hEF);
        check_eq("reload_addr", imem_addr, 0);
        check_eq("reload_data", imem_data, 16'hBEEF);
        @(posedge clk); #1;
        check_eq("reload_ack", tx_data, 8'h5A);
        @(posedge clk); #1;
        check_eq("reload_cpu_en", cpu_enable, 1);
        send_byte(8'h3C);
        $display("txn reload: 0xBEEF@0");

        // Asynchronous reset in the middle of a two-word load.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check_eq("midrst_busy_before", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_addr", imem_addr, 0);
        check_eq("midrst_we", imem_we, 0);
        check_eq("midrst_cpu_en", cpu_enable, 0);
        check_eq("midrst_mem0", mem_seen[0], 16'h1122);
        @(posedge clk); #1 rst_n = 1'b1;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hCA); send_byte(8'hFE);
        check_eq("postrst_addr", imem_addr, 0);
        check_eq("postrst_data", imem_data, 16'hCAFE);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("postrst_cpu_en", cpu_enable, 1);
        send_byte(8'h3C);
        $display("txn midreset: restart at 0");

        // Full-depth load ends on address 2047 without wrapping.
        we_base = we_cnt;
        send_byte(8'hA5); send_byte(8'h08); send_byte(8'h00);
        for (int i = 0; i < 2048; i++) begin
            w = 16'(i) ^ 16'h5A00;
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        check_eq("full_last_addr", imem_addr, 11'h7FF);
        @(posedge clk); #1;
        check_eq("full_ack", tx_data, 8'h5A);
        check_eq("full_no_wrap", imem_addr, 11'h7FF);
        check_eq("full_we_cnt", we_cnt - we_base, 2048);
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            w = 16'(i) ^ 16'h5A00;
            if (mem_seen[i] !== w) bad++;
        end
        check_eq("full_mem_bad", bad, 0);
        check_eq("full_we_double", we_double, 0);
        @(posedge clk); #1;
        check_eq("full_cpu_en", cpu_enable, 1);
        send_byte(8'h3C);
        $display("txn full: 2048 words");

`ifdef BIP_BOOT_TIMEOUT_EN
        send_byte(8'hA5);
        wait_tx(200, cyc);
        check_eq("tmo_valid", tx_valid, 1);
        check_eq("tmo_cycles", cyc, 100);
        check_eq("tmo_data", tx_data, 8'hFE);
        @(posedge clk); #1;
        check_eq("tmo_busy", busy, 0);
        check_eq("tmo_cpu_en", cpu_enable, 0);
        $display("txn timeout: nak 0xFE");
`else
        send_byte(8'hA5);
        wait_tx(300, cyc);
        check_eq("notmo_valid", tx_valid, 0);
        check_eq("notmo_busy", busy, 1);
        send_byte(8'h00); send_byte(8'h00);
        check_eq("notmo_ack", tx_data, 8'h5A);
        @(posedge clk); #1;
        send_byte(8'h3C);
        $display("txn no-timeout: stall held");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
